// File: rtl/multi_dispatcher_pkg.sv
// Shared types and defaults for the multi_dispatcher dispatch stage.
package multi_dispatcher_pkg;

    localparam int DEF_DISPATCH_WIDTH = 2;
    localparam int DEF_IQ_DEPTH       = 8;
    localparam int DEF_NUM_FU         = 4;
    localparam int DEF_INSN_W         = 128;
    localparam int DEF_ROB_SIZE       = 32;
    localparam int DEF_RS_CNT_W       = 3;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_LSU  = 2'd1,
        FU_MULT = 2'd2,
        FU_BTU  = 2'd3
    } fu_sel_e;

    typedef struct packed {
        fu_sel_e                 fu;
        logic [DEF_INSN_W-1:0]   insn;
    } iq_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/multi_dispatcher_if.sv
// Decoder-side enqueue, credit inputs and dispatch outputs of multi_dispatcher.
interface multi_dispatcher_if #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int IQ_DEPTH       = 8,
    parameter int NUM_FU         = 4,
    parameter int INSN_W         = 128,
    parameter int ROB_SIZE       = 32,
    parameter int RS_CNT_W       = 3
);
    localparam int W      = DISPATCH_WIDTH;
    localparam int FU_W   = $clog2(NUM_FU);
    localparam int TAG_W  = $clog2(ROB_SIZE);
    localparam int ROBF_W = $clog2(ROB_SIZE + 1);
    localparam int DC_W   = $clog2(W + 1);
    localparam int CNT_W  = $clog2(IQ_DEPTH + 1);

    // Enqueue slot i transfers at an edge where enq_valid[i] && enq_ready;
    // enq_ready depends only on registered occupancy. Dispatch has no ready:
    // credits arrive up front and disp_valid[i] means slot i was issued.
    logic                     flush;
    logic [W-1:0]             enq_valid;
    logic [W*FU_W-1:0]        enq_fu;
    logic [W*INSN_W-1:0]      enq_insn;
    logic                     enq_ready;
    logic [NUM_FU*RS_CNT_W-1:0] rs_free_cnt;
    logic [ROBF_W-1:0]        rob_free_cnt;
    logic [TAG_W-1:0]         rob_tail_tag;
    logic [W-1:0]             disp_valid;
    logic [W*INSN_W-1:0]      disp_insn;
    logic [W*TAG_W-1:0]       disp_rob_tag;
    logic [W*NUM_FU-1:0]      rs_load;
    logic [DC_W-1:0]          disp_count;
    logic [CNT_W-1:0]         iq_count;

    modport master (
        output flush, enq_valid, enq_fu, enq_insn, rs_free_cnt, rob_free_cnt, rob_tail_tag,
        input  enq_ready, disp_valid, disp_insn, disp_rob_tag, rs_load, disp_count, iq_count
    );

    modport slave (
        input  flush, enq_valid, enq_fu, enq_insn, rs_free_cnt, rob_free_cnt, rob_tail_tag,
        output enq_ready, disp_valid, disp_insn, disp_rob_tag, rs_load, disp_count, iq_count
    );

endinterface

// File: rtl/multi_dispatcher_select.sv
// In-order prefix selection: a slot issues only if every earlier slot issued and
// ROB space plus per-FU RS credit remain after the slots ahead of it.
module multi_dispatcher_select #(
    parameter int W        = 2,
    parameter int NUM_FU   = 4,
    parameter int RS_CNT_W = 3,
    parameter int CNT_W    = 4,
    parameter int ROBF_W   = 6,
    parameter int FU_W     = $clog2(NUM_FU),
    parameter int DC_W     = $clog2(W + 1)
) (
    input  logic [CNT_W-1:0]           count,
    input  logic [W*FU_W-1:0]          slot_fu,
    input  logic [NUM_FU*RS_CNT_W-1:0] rs_free_cnt,
    input  logic [ROBF_W-1:0]          rob_free_cnt,
    output logic [W-1:0]               issue,
    output logic [W*NUM_FU-1:0]        rs_load,
    output logic [DC_W-1:0]            disp_count
);

    logic [RS_CNT_W-1:0] free_cnt [NUM_FU];
    int                  used     [NUM_FU];
    logic [FU_W-1:0]     fu;
    logic                open;

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            free_cnt[f] = rs_free_cnt[f*RS_CNT_W +: RS_CNT_W];
        end
    end

    always_comb begin
        issue      = '0;
        rs_load    = '0;
        disp_count = '0;
        open       = 1'b1;
        fu         = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            used[f] = 0;
        end
        for (int i = 0; i < W; i++) begin
            fu = slot_fu[i*FU_W +: FU_W];
            if (open && (i < int'(count)) && (i < int'(rob_free_cnt)) &&
                (used[fu] < int'(free_cnt[fu]))) begin
                issue[i]                    = 1'b1;
                rs_load[i*NUM_FU + int'(fu)] = 1'b1;
                used[fu]                    = used[fu] + 1;
                disp_count                  = disp_count + DC_W'(1);
            end else begin
                open = 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_dispatcher.sv
// Dispatch stage: circular instruction queue feeding the in-order prefix selector.
// Define DISPATCH_PERF_EN to add saturating ROB-stall, RS-stall and empty counters.
module multi_dispatcher
    import multi_dispatcher_pkg::*;
#(
    parameter int DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
    parameter int IQ_DEPTH       = DEF_IQ_DEPTH,
    parameter int NUM_FU         = DEF_NUM_FU,
    parameter int INSN_W         = DEF_INSN_W,
    parameter int ROB_SIZE       = DEF_ROB_SIZE,
    parameter int RS_CNT_W       = DEF_RS_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
`ifdef DISPATCH_PERF_EN
    output logic [31:0] perf_stall_rob,
    output logic [31:0] perf_stall_rs,
    output logic [31:0] perf_empty,
`endif
    multi_dispatcher_if.slave io
);

    localparam int W      = DISPATCH_WIDTH;
    localparam int FU_W   = $clog2(NUM_FU);
    localparam int PTR_W  = $clog2(IQ_DEPTH);
    localparam int CNT_W  = $clog2(IQ_DEPTH + 1);
    localparam int TAG_W  = $clog2(ROB_SIZE);
    localparam int ROBF_W = $clog2(ROB_SIZE + 1);
    localparam int DC_W   = $clog2(W + 1);

    typedef struct packed {
        logic [FU_W-1:0]   fu;
        logic [INSN_W-1:0] insn;
    } entry_t;

    entry_t             iq_q [IQ_DEPTH];
    entry_t             iq_d [IQ_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [W*FU_W-1:0]  slot_fu;
    logic [W-1:0]       issue, enq_keep;
    logic [DC_W-1:0]    disp_n, enq_n, enq_acc_n;
    logic               enq_ready;

    assign enq_ready     = (CNT_W'(IQ_DEPTH) - count_q) >= CNT_W'(W);
    assign enq_acc_n     = enq_ready ? enq_n : '0;
    assign io.enq_ready  = enq_ready;
    assign io.iq_count   = count_q;
    assign io.disp_valid = issue;
    assign io.disp_count = disp_n;

    always_comb begin
        slot_fu         = '0;
        io.disp_insn    = '0;
        io.disp_rob_tag = '0;
        for (int i = 0; i < W; i++) begin
            slot_fu[i*FU_W +: FU_W] = iq_q[head_q + PTR_W'(i)].fu;
            if (issue[i]) begin
                io.disp_insn[i*INSN_W +: INSN_W]   = iq_q[head_q + PTR_W'(i)].insn;
                io.disp_rob_tag[i*TAG_W +: TAG_W]  = io.rob_tail_tag + TAG_W'(i);
            end
        end
    end

    multi_dispatcher_select #(
        .W        (W),
        .NUM_FU   (NUM_FU),
        .RS_CNT_W (RS_CNT_W),
        .CNT_W    (CNT_W),
        .ROBF_W   (ROBF_W),
        .FU_W     (FU_W),
        .DC_W     (DC_W)
    ) u_select (
        .count        (count_q),
        .slot_fu      (slot_fu),
        .rs_free_cnt  (io.rs_free_cnt),
        .rob_free_cnt (io.rob_free_cnt),
        .issue        (issue),
        .rs_load      (io.rs_load),
        .disp_count   (disp_n)
    );

    // Only the leading run of valid slots is accepted; anything after a gap is dropped.
    always_comb begin
        enq_keep    = '0;
        enq_n       = '0;
        enq_keep[0] = io.enq_valid[0];
        for (int i = 1; i < W; i++) begin
            enq_keep[i] = io.enq_valid[i] & enq_keep[i-1];
        end
        for (int i = 0; i < W; i++) begin
            if (enq_keep[i]) enq_n = enq_n + DC_W'(1);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        iq_d    = iq_q;
        if (io.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_ready) begin
                for (int i = 0; i < W; i++) begin
                    if (enq_keep[i]) begin
                        iq_d[tail_q + PTR_W'(i)].fu   = io.enq_fu[i*FU_W +: FU_W];
                        iq_d[tail_q + PTR_W'(i)].insn = io.enq_insn[i*INSN_W +: INSN_W];
                    end
                end
            end
            head_d  = head_q + PTR_W'(disp_n);
            tail_d  = tail_q + PTR_W'(enq_acc_n);
            count_d = count_q + CNT_W'(enq_acc_n) - CNT_W'(disp_n);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            iq_q    <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            iq_q    <= iq_d;
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [31:0]         stall_rob_q, stall_rob_d;
    logic [31:0]         stall_rs_q, stall_rs_d;
    logic [31:0]         empty_q, empty_d;
    logic [RS_CNT_W-1:0] slot0_rs_free;

    always_comb begin
        slot0_rs_free = io.rs_free_cnt[int'(slot_fu[FU_W-1:0])*RS_CNT_W +: RS_CNT_W];
        stall_rob_d   = sat_inc(stall_rob_q, (count_q != '0) && (io.rob_free_cnt == '0));
        stall_rs_d    = sat_inc(stall_rs_q, (count_q != '0) && (slot0_rs_free == '0));
        empty_d       = sat_inc(empty_q, count_q == '0);
    end

    // Counters survive flush; only reset_n clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_rob_q <= '0;
            stall_rs_q  <= '0;
            empty_q     <= '0;
        end else begin
            stall_rob_q <= stall_rob_d;
            stall_rs_q  <= stall_rs_d;
            empty_q     <= empty_d;
        end
    end

    assign perf_stall_rob = stall_rob_q;
    assign perf_stall_rs  = stall_rs_q;
    assign perf_empty     = empty_q;
`endif

endmodule

// File: tb/tb_multi_dispatcher.sv
// Directed bench for multi_dispatcher (W=2, depth 8): credits, ordering, wrap, flush, async reset.
module tb_multi_dispatcher;
  import multi_dispatcher_pkg::*;

  localparam int W = 2, IQ_DEPTH = 8, NUM_FU = 4, INSN_W = 128, ROB_SIZE = 32, RS_CNT_W = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  multi_dispatcher_if #(
    .DISPATCH_WIDTH(W), .IQ_DEPTH(IQ_DEPTH), .NUM_FU(NUM_FU),
    .INSN_W(INSN_W), .ROB_SIZE(ROB_SIZE), .RS_CNT_W(RS_CNT_W)
  ) dif ();

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_stall_rob, perf_stall_rs, perf_empty;
`endif

  multi_dispatcher #(
    .DISPATCH_WIDTH(W), .IQ_DEPTH(IQ_DEPTH), .NUM_FU(NUM_FU),
    .INSN_W(INSN_W), .ROB_SIZE(ROB_SIZE), .RS_CNT_W(RS_CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
`ifdef DISPATCH_PERF_EN
    .perf_stall_rob (perf_stall_rob),
    .perf_stall_rs  (perf_stall_rs),
    .perf_empty     (perf_empty),
`endif
    .io             (dif.slave)
  );

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      assert (dif.enq_valid !== 2'b10) else $error("protocol violation: non-contiguous enq_valid");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    dif.flush     = 1'b0;
    dif.enq_valid = '0;
    dif.enq_fu    = '0;
    dif.enq_insn  = '0;
  endtask

  task automatic set_credit(input int alu, input int lsu, input int mult, input int btu,
                            input int rob, input int tag);
    dif.rs_free_cnt  = {3'(btu), 3'(mult), 3'(lsu), 3'(alu)};
    dif.rob_free_cnt = 6'(rob);
    dif.rob_tail_tag = 5'(tag);
  endtask

  task automatic enq2(input logic [1:0] v, input logic [1:0] f0, input logic [1:0] f1,
                      input logic [127:0] i0, input logic [127:0] i1);
    dif.enq_valid = v;
    dif.enq_fu    = {f1, f0};
    dif.enq_insn  = {i1, i0};
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_cnt++; if (dif.disp_valid !== 2'b00) $display("FAIL reset_disp_valid: got %b want 00", dif.disp_valid); else pass_cnt++;
    total_cnt++; if (dif.rs_load !== 8'h00) $display("FAIL reset_rs_load: got %h want 00", dif.rs_load); else pass_cnt++;
    total_cnt++; if (dif.disp_count !== 2'd0) $display("FAIL reset_disp_count: got %0d want 0", dif.disp_count); else pass_cnt++;
    total_cnt++; if (dif.iq_count !== 4'd0) $display("FAIL reset_iq_count: got %0d want 0", dif.iq_count); else pass_cnt++;
    total_cnt++; if (dif.enq_ready !== 1'b1) $display("FAIL reset_enq_ready: got %b want 1", dif.enq_ready); else pass_cnt++;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_alu_pair();
    set_credit(4, 0, 0, 0, 8, 30);
    enq2(2'b11, FU_ALU, FU_ALU, 128'hA0, 128'hA1);
    @(negedge clk);
    total_cnt++; if (dif.disp_valid !== 2'b00) $display("FAIL alu_no_bypass: got %b want 00", dif.disp_valid); else pass_cnt++;
    tick();
    set_idle();
    @(negedge clk);
    total_cnt++; if (dif.disp_valid !== 2'b11) $display("FAIL alu_valid: got %b want 11", dif.disp_valid); else pass_cnt++;
    total_cnt++; if (dif.disp_rob_tag !== {5'd31, 5'd30}) $display("FAIL alu_tags: got %h want %h", dif.disp_rob_tag, {5'd31, 5'd30}); else pass_cnt++;
    total_cnt++; if (dif.rs_load !== 8'b0001_0001) $display("FAIL alu_rs_load: got %b want 00010001", dif.rs_load); else pass_cnt++;
    total_cnt++; if (dif.disp_insn !== {128'hA1, 128'hA0}) $display("FAIL alu_insn: got %h want a1/a0", dif.disp_insn); else pass_cnt++;
    total_cnt++; if (dif.disp_count !== 2'd2) $display("FAIL alu_disp_count: got %0d want 2", dif.disp_count); else pass_cnt++;
    total_cnt++; if (dif.iq_count !== 4'd2) $display("FAIL alu_iq_before: got %0d want 2", dif.iq_count); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (dif.iq_count !== 4'd0) $display("FAIL alu_iq_after: got %0d want 0", dif.iq_count); else pass_cnt++;
    total_cnt++; if (dif.disp_valid !== 2'b00) $display("FAIL alu_valid_after: got %b want 00", dif.disp_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_rs_credit();
    set_credit(0, 0, 1, 0, 8, 0);
    enq2(2'b11, FU_MULT, FU_MULT, 128'hB0, 128'hB1);
    tick();
    set_idle();
    @(negedge clk);
    total_cnt++; if (dif.disp_valid !== 2'b01) $display("FAIL rs_first_valid: got %b want 01", dif.disp_valid); else pass_cnt++;
    total_cnt++; if (dif.rs_load !== 8'b0000_0100) $display("FAIL rs_first_load: got %b want 00000100", dif.rs_load); else pass_cnt++;
    total_cnt++; if (dif.disp_insn[127:0] !== 128'hB0) $display("FAIL rs_first_insn: got %h want b0", dif.disp_insn[127:0]); else pass_cnt++;
    total_cnt++; if (dif.disp_count !== 2'd1) $display("FAIL rs_first_count: got %0d want 1", dif.disp_count); else pass_cnt++;
    tick();
    dif.rob_tail_tag = 5'd1;
    @(negedge clk);
    total_cnt++; if (dif.disp_valid !== 2'b01) $display("FAIL rs_second_valid: got %b want 01", dif.disp_valid); else pass_cnt++;
    total_cnt++; if (dif.disp_insn[127:0] !== 128'hB1) $display("FAIL rs_second_insn: got %h want b1", dif.disp_insn[127:0]); else pass_cnt++;
    total_cnt++; if (dif.disp_rob_tag[4:0] !== 5'd1) $display("FAIL rs_second_tag: got %0d want 1", dif.disp_rob_tag[4:0]); else pass_cnt++;
    total_cnt++; if (dif.iq_count !== 4'd1) $display("FAIL rs_second_iq: got %0d want 1", dif.iq_count); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (dif.iq_count !== 4'd0) $display("FAIL rs_drained: got %0d want 0", dif.iq_count); else pass_cnt++;
    tick();
  endtask

  task automatic test_rob_credit();
    set_credit(4, 0, 0, 0, 0, 5);
    enq2(2'b11, FU_ALU, FU_ALU, 128'hC0, 128'hC1);
    tick();
    set_idle();
    @(negedge clk);
    total_cnt++; if (dif.disp_valid !== 2'b00) $display("FAIL rob0_valid: got %b want 00", dif.disp_valid); else pass_cnt++;
    tick();
    dif.rob_free_cnt = 6'd1;
    @(negedge clk);
    total_cnt++; if (dif.iq_count !== 4'd2) $display("FAIL rob0_held: got %0d want 2", dif.iq_count); else pass_cnt++;
    total_cnt++; if (dif.disp_count !== 2'd1) $display("FAIL rob1_count: got %0d want 1", dif.disp_count); else pass_cnt++;
    total_cnt++; if (dif.disp_valid !== 2'b01) $display("FAIL rob1_valid: got %b want 01", dif.disp_valid); else pass_cnt++;
    tick();
    dif.rob_free_cnt = 6'd8;
    @(negedge clk);
    total_cnt++; if (dif.disp_insn !== {128'h0, 128'hC1}) $display("FAIL rob_rest_insn: got %h want 0/c1", dif.disp_insn); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (dif.iq_count !== 4'd0) $display("FAIL rob_drained: got %0d want 0", dif.iq_count); else pass_cnt++;
    tick();
  endtask

  task automatic test_fill_wrap();
    set_credit(0, 0, 0, 0, 8, 0);
    for (int c = 0; c < 4; c++) begin
      enq2(2'b11, FU_ALU, FU_ALU, 128'(16 + 2*c), 128'(17 + 2*c));
      tick();
    end
    enq2(2'b11, FU_ALU, FU_ALU, 128'hDEAD, 128'hBEEF);
    @(negedge clk);
    total_cnt++; if (dif.iq_count !== 4'd8) $display("FAIL full_iq: got %0d want 8", dif.iq_count); else pass_cnt++;
    total_cnt++; if (dif.enq_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", dif.enq_ready); else pass_cnt++;
    tick();
    set_idle();
    set_credit(4, 0, 0, 0, 8, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total_cnt++;
      if (dif.disp_insn !== {128'(17 + 2*c), 128'(16 + 2*c)})
        $display("FAIL wrap_order_%0d: got %h want %0d/%0d", c, dif.disp_insn, 17 + 2*c, 16 + 2*c);
      else pass_cnt++;
      total_cnt++;
      if (dif.iq_count !== 4'(8 - 2*c)) $display("FAIL wrap_iq_%0d: got %0d want %0d", c, dif.iq_count, 8 - 2*c);
      else pass_cnt++;
      tick();
    end
    @(negedge clk);
    total_cnt++; if (dif.disp_valid !== 2'b00) $display("FAIL wrap_dropped: got %b want 00", dif.disp_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_mixed_fu();
    set_credit(0, 1, 0, 1, 8, 7);
    enq2(2'b11, FU_LSU, FU_BTU, 128'hD0, 128'hD1);
    tick();
    set_idle();
    @(negedge clk);
    total_cnt++; if (dif.rs_load !== 8'b1000_0010) $display("FAIL mixed_rs_load: got %b want 10000010", dif.rs_load); else pass_cnt++;
    total_cnt++; if (dif.disp_rob_tag !== {5'd8, 5'd7}) $display("FAIL mixed_tags: got %h want %h", dif.disp_rob_tag, {5'd8, 5'd7}); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    set_credit(0, 0, 0, 0, 8, 0);
    enq2(2'b11, FU_ALU, FU_ALU, 128'hE0, 128'hE1);
    tick();
    set_credit(4, 0, 0, 0, 8, 0);
    dif.flush = 1'b1;
    enq2(2'b11, FU_ALU, FU_ALU, 128'hF0, 128'hF1);
    @(negedge clk);
    total_cnt++; if (dif.disp_insn !== {128'hE1, 128'hE0}) $display("FAIL flush_cycle_insn: got %h want e1/e0", dif.disp_insn); else pass_cnt++;
    tick();
    set_idle();
    @(negedge clk);
    total_cnt++; if (dif.iq_count !== 4'd0) $display("FAIL flush_iq: got %0d want 0", dif.iq_count); else pass_cnt++;
    total_cnt++; if (dif.disp_valid !== 2'b00) $display("FAIL flush_dropped: got %b want 00", dif.disp_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_async_reset();
    set_credit(0, 0, 0, 0, 8, 0);
    enq2(2'b11, FU_ALU, FU_ALU, 128'h10, 128'h11);
    tick();
    enq2(2'b11, FU_ALU, FU_ALU, 128'h12, 128'h13);
    tick();
    enq2(2'b01, FU_ALU, FU_ALU, 128'h14, 128'h0);
    tick();
    set_idle();
    set_credit(4, 0, 0, 0, 8, 0);
    @(negedge clk);
    total_cnt++; if (dif.iq_count !== 4'd5) $display("FAIL arst_pre_iq: got %0d want 5", dif.iq_count); else pass_cnt++;
    total_cnt++; if (dif.disp_valid !== 2'b11) $display("FAIL arst_pre_valid: got %b want 11", dif.disp_valid); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (dif.iq_count !== 4'd0) $display("FAIL arst_iq: got %0d want 0", dif.iq_count); else pass_cnt++;
    total_cnt++; if (dif.disp_valid !== 2'b00) $display("FAIL arst_valid: got %b want 00", dif.disp_valid); else pass_cnt++;
    total_cnt++; if (dif.rs_load !== 8'h00) $display("FAIL arst_rs_load: got %h want 00", dif.rs_load); else pass_cnt++;
    total_cnt++; if (dif.disp_count !== 2'd0) $display("FAIL arst_count: got %0d want 0", dif.disp_count); else pass_cnt++;
    total_cnt++; if (dif.enq_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", dif.enq_ready); else pass_cnt++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (dif.iq_count !== 4'd0) $display("FAIL arst_release_iq: got %0d want 0", dif.iq_count); else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    set_idle();
    set_credit(0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_pair();
    test_rs_credit();
    test_rob_credit();
    test_fill_wrap();
    test_mixed_fu();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
